commit_ctrl: RTL and testbench

Retirement and trap controller sitting directly downstream of the reorder-buffer commit port. Each cycle it consumes at most one committed instruction and does one of three things:
- retires it into the architectural register map;
- starts an exception sequence;
- starts an `mret` return.

For exceptions and returns it latches `mepc`/`mcause`, stalls further commits while the pipeline drains, then issues a one-cycle front-end redirect. It also maintains the retired-instruction counter.

---
 rtl/commit_ctrl.sv | 165 ++++++++++++++++
 tb/tb_commit_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/commit_ctrl.sv
// Commit-side retirement and trap controller: retires ROB commits into the
// architectural map, sequences exception/mret drain and the front-end redirect.
package commit_ctrl_pkg;
   typedef struct packed {
      logic [4:0] addr;
   } RegFile_t;

   typedef logic [3:0] ExpCode_t;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DRAIN    = 2'd1,
      REDIRECT = 2'd2
   } state_e;
endpackage

module commit_ctrl
   import commit_ctrl_pkg::*;
#(
   parameter int unsigned     ADDR         = 32,
   parameter int unsigned     ROB_DEPTH    = 16,
   parameter logic [ADDR-1:0] TRAP_VEC     = 'h100,
   parameter int unsigned     DRAIN_CYCLES = 2,
   localparam int unsigned    ROB          = $clog2(ROB_DEPTH)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            com_e_,
   input  logic [ADDR-1:0] com_pc,
   input  RegFile_t        com_rd,
   input  logic [ROB-1:0]  com_rob_id,
   input  logic            com_exp_,
   input  ExpCode_t        com_exp_code,
   input  logic            com_mret_,
   output logic            arch_we_,
   output RegFile_t        arch_rd,
   output logic [ROB-1:0]  arch_rob_id,
   output logic            com_stall_,
   output logic            trap_e_,
   output logic [ADDR-1:0] trap_pc,
   output logic [ADDR-1:0] mepc,
   output ExpCode_t        mcause,
   output logic [63:0]     instret
);

   localparam logic [3:0] DrainLoad = 4'(DRAIN_CYCLES - 1);

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [ADDR-1:0] target_q, target_d;
   logic            arch_we_q, arch_we_d;
   RegFile_t        arch_rd_q, arch_rd_d;
   logic [ROB-1:0]  arch_rob_id_q, arch_rob_id_d;
   logic            stall_q, stall_d;
   logic            trap_e_q, trap_e_d;
   logic [ADDR-1:0] trap_pc_q, trap_pc_d;
   logic [ADDR-1:0] mepc_q, mepc_d;
   ExpCode_t        mcause_q, mcause_d;
   logic [63:0]     instret_q, instret_d;

   logic accept;
   logic take_trap;

   assign accept    = !com_e_ && (state_q == RUN);
   assign take_trap = accept && (!com_exp_ || !com_mret_);

   // State register plus every registered output; reset is synchronous.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // sample the same pre-edge values regardless of statement order.
      if (reset) begin
         state_q       <= RUN;
         cnt_q         <= '0;
         target_q      <= '0;
         arch_we_q     <= 1'b1;
         arch_rd_q     <= '0;
         arch_rob_id_q <= '0;
         stall_q       <= 1'b1;
         trap_e_q      <= 1'b1;
         trap_pc_q     <= '0;
         mepc_q        <= '0;
         mcause_q      <= '0;
         instret_q     <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         target_q      <= target_d;
         arch_we_q     <= arch_we_d;
         arch_rd_q     <= arch_rd_d;
         arch_rob_id_q <= arch_rob_id_d;
         stall_q       <= stall_d;
         trap_e_q      <= trap_e_d;
         trap_pc_q     <= trap_pc_d;
         mepc_q        <= mepc_d;
         mcause_q      <= mcause_d;
         instret_q     <= instret_d;
      end
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every signal; no latches.
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RUN: begin
            if (take_trap) begin
               state_d = DRAIN;
               cnt_d   = DrainLoad;
            end
         end
         DRAIN: begin
            if (cnt_q == 4'd0) state_d = REDIRECT;
            else               cnt_d   = cnt_q - 4'd1;
         end
         REDIRECT: state_d = RUN;
         default:  state_d = RUN;
      endcase
   end

   always_comb begin
      arch_we_d     = 1'b1;
      arch_rd_d     = arch_rd_q;
      arch_rob_id_d = arch_rob_id_q;
      mepc_d        = mepc_q;
      mcause_d      = mcause_q;
      target_d      = target_q;
      instret_d     = instret_q;

      if (accept) begin
         if (!com_exp_) begin
            // Exception wins over mret and does not count as retired.
            mepc_d   = com_pc;
            mcause_d = com_exp_code;
            target_d = TRAP_VEC;
         end else if (!com_mret_) begin
            target_d  = mepc_q;
            instret_d = instret_q + 64'd1;
         end else begin
            instret_d = instret_q + 64'd1;
            if (com_rd.addr != 5'd0) begin
               arch_we_d     = 1'b0;
               arch_rd_d     = com_rd;
               arch_rob_id_d = com_rob_id;
            end
         end
      end

      // Stall and redirect are registered from the next state so they line up
      // with the cycles the FSM actually occupies.
      stall_d   = (state_d == RUN);
      trap_e_d  = (state_d != REDIRECT);
      trap_pc_d = (state_d == REDIRECT) ? target_q : '0;
   end

   assign arch_we_    = arch_we_q;
   assign arch_rd     = arch_rd_q;
   assign arch_rob_id = arch_rob_id_q;
   assign com_stall_  = stall_q;
   assign trap_e_     = trap_e_q;
   assign trap_pc     = trap_pc_q;
   assign mepc        = mepc_q;
   assign mcause      = mcause_q;
   assign instret     = instret_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed self-checking bench for commit_ctrl: retire, exception, mret,
// priority, reset mid-drain and instret wrap.
module tb_commit_ctrl;
   import commit_ctrl_pkg::*;

   localparam int unsigned ADDR = 32;
   localparam int unsigned ROB  = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            com_e_;
   logic [ADDR-1:0] com_pc;
   RegFile_t        com_rd;
   logic [ROB-1:0]  com_rob_id;
   logic            com_exp_;
   ExpCode_t        com_exp_code;
   logic            com_mret_;
   logic            arch_we_;
   RegFile_t        arch_rd;
   logic [ROB-1:0]  arch_rob_id;
   logic            com_stall_;
   logic            trap_e_;
   logic [ADDR-1:0] trap_pc;
   logic [ADDR-1:0] mepc;
   ExpCode_t        mcause;
   logic [63:0]     instret;

   int n_tests = 0;
   int n_fail  = 0;

   commit_ctrl #(
      .ADDR(ADDR), .ROB_DEPTH(16), .TRAP_VEC('h100), .DRAIN_CYCLES(2)
   ) dut (
      .clk(clk), .reset(reset),
      .com_e_(com_e_), .com_pc(com_pc), .com_rd(com_rd), .com_rob_id(com_rob_id),
      .com_exp_(com_exp_), .com_exp_code(com_exp_code), .com_mret_(com_mret_),
      .arch_we_(arch_we_), .arch_rd(arch_rd), .arch_rob_id(arch_rob_id),
      .com_stall_(com_stall_), .trap_e_(trap_e_), .trap_pc(trap_pc),
      .mepc(mepc), .mcause(mcause), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      com_e_    = 1'b1;
      com_exp_  = 1'b1;
      com_mret_ = 1'b1;
   endtask

   task automatic retire(input logic [4:0] rd, input logic [ROB-1:0] rob);
      com_e_      = 1'b0;
      com_exp_    = 1'b1;
      com_mret_   = 1'b1;
      com_rd.addr = rd;
      com_rob_id  = rob;
   endtask

   initial begin
      reset        = 1'b1;
      com_pc       = '0;
      com_rd       = '0;
      com_rob_id   = '0;
      com_exp_code = '0;
      idle();
      step();
      step();
      reset = 1'b0;

      // Reset state
      check("rst_we",      64'(arch_we_),    64'd1);
      check("rst_rd",      64'(arch_rd),     64'd0);
      check("rst_rob",     64'(arch_rob_id), 64'd0);
      check("rst_stall",   64'(com_stall_),  64'd1);
      check("rst_trap_e",  64'(trap_e_),     64'd1);
      check("rst_trap_pc", 64'(trap_pc),     64'd0);
      check("rst_mepc",    64'(mepc),        64'd0);
      check("rst_mcause",  64'(mcause),      64'd0);
      check("rst_instret", instret,          64'd0);

      // Back-to-back retires, middle one to x0
      retire(5'd5, 4'd3);
      step();
      check("ret1_we",  64'(arch_we_),    64'd0);
      check("ret1_rd",  64'(arch_rd),     64'd5);
      check("ret1_rob", 64'(arch_rob_id), 64'd3);
      check("ret1_cnt", instret,          64'd1);
      retire(5'd0, 4'd4);
      step();
      check("ret0_we",  64'(arch_we_), 64'd1);
      check("ret0_cnt", instret,       64'd2);
      retire(5'd7, 4'd5);
      step();
      check("ret2_we",  64'(arch_we_),    64'd0);
      check("ret2_rd",  64'(arch_rd),     64'd7);
      check("ret2_rob", 64'(arch_rob_id), 64'd5);
      check("ret2_cnt", instret,          64'd3);
      idle();
      step();
      check("ret_idle_we", 64'(arch_we_), 64'd1);

      // Exception at 0x40 code 2, com_e_ held low throughout
      com_e_       = 1'b0;
      com_exp_     = 1'b0;
      com_pc       = 32'h40;
      com_exp_code = 4'd2;
      step();                                   // T+1
      check("exc_mepc",    64'(mepc),       64'h40);
      check("exc_mcause",  64'(mcause),     64'd2);
      check("exc_stall1",  64'(com_stall_), 64'd0);
      check("exc_trap1",   64'(trap_e_),    64'd1);
      check("exc_cnt1",    instret,         64'd3);
      com_exp_    = 1'b1;
      com_rd.addr = 5'd9;
      com_pc      = 32'h44;
      step();                                   // T+2
      check("exc_stall2",  64'(com_stall_), 64'd0);
      check("exc_trap2",   64'(trap_e_),    64'd1);
      check("exc_we2",     64'(arch_we_),   64'd1);
      step();                                   // T+3
      check("exc_trap3",   64'(trap_e_),    64'd0);
      check("exc_tpc3",    64'(trap_pc),    64'h100);
      check("exc_stall3",  64'(com_stall_), 64'd0);
      check("exc_we3",     64'(arch_we_),   64'd1);
      check("exc_cnt3",    instret,         64'd3);
      idle();
      step();                                   // T+4
      check("exc_stall4",  64'(com_stall_), 64'd1);
      check("exc_trap4",   64'(trap_e_),    64'd1);
      check("exc_cnt4",    instret,         64'd3);

      // mret returns to mepc
      com_e_    = 1'b0;
      com_mret_ = 1'b0;
      com_pc    = 32'h80;
      step();
      check("mret_cnt",    instret,         64'd4);
      check("mret_mepc",   64'(mepc),       64'h40);
      check("mret_mcause", 64'(mcause),     64'd2);
      check("mret_stall",  64'(com_stall_), 64'd0);
      check("mret_we",     64'(arch_we_),   64'd1);
      idle();
      step();
      step();
      check("mret_trap",   64'(trap_e_),    64'd0);
      check("mret_tpc",    64'(trap_pc),    64'h40);
      step();
      check("mret_stall4", 64'(com_stall_), 64'd1);

      // Exception and mret together: exception wins
      com_e_       = 1'b0;
      com_exp_     = 1'b0;
      com_mret_    = 1'b0;
      com_pc       = 32'h88;
      com_exp_code = 4'd5;
      step();
      check("both_mepc",   64'(mepc),   64'h88);
      check("both_mcause", 64'(mcause), 64'd5);
      check("both_cnt",    instret,     64'd4);
      idle();
      step();
      step();
      check("both_trap",   64'(trap_e_), 64'd0);
      check("both_tpc",    64'(trap_pc), 64'h100);
      step();

      // Reset during drain discards the redirect
      com_e_       = 1'b0;
      com_exp_     = 1'b0;
      com_pc       = 32'hC0;
      com_exp_code = 4'd3;
      step();                                   // T+1
      check("rsd_mepc1",  64'(mepc), 64'hC0);
      idle();
      step();                                   // T+2
      reset = 1'b1;
      step();                                   // T+3
      reset = 1'b0;
      check("rsd_trap3",  64'(trap_e_),    64'd1);
      check("rsd_stall3", 64'(com_stall_), 64'd1);
      check("rsd_mepc3",  64'(mepc),       64'd0);
      check("rsd_cnt3",   instret,         64'd0);
      step();                                   // T+4
      check("rsd_trap4",  64'(trap_e_),    64'd1);
      retire(5'd3, 4'd1);
      step();
      check("rsd_acc_we",  64'(arch_we_), 64'd0);
      check("rsd_acc_cnt", instret,       64'd1);
      idle();
      step();

      // instret wraps from all-ones to zero
      force dut.instret_q = '1;
      #1;
      release dut.instret_q;
      check("wrap_pre", instret, 64'hFFFF_FFFF_FFFF_FFFF);
      retire(5'd0, 4'd2);
      step();
      check("wrap_zero", instret, 64'd0);
      step();
      check("wrap_one",  instret, 64'd1);
      idle();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
